// File: rtl/alu_seq_pkg.sv
// Shared types, opcode constants and decode helpers for the ALU issue/writeback sequencer.
package alu_seq_pkg;

  localparam int NREGS_C = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2,
    ILL   = 2'd3
  } state_t;

  // Two-operand ops: bit 7 set, bits 6:1 are the base code, bit 0 selects register form
  localparam logic [7:0] OP_ADD  = 8'h88;
  localparam logic [7:0] OP_SUB  = 8'h8A;
  localparam logic [7:0] OP_MUL  = 8'h90;
  localparam logic [7:0] OP_AND  = 8'h94;
  localparam logic [7:0] OP_OR   = 8'h96;
  localparam logic [7:0] OP_XOR  = 8'h98;

  localparam logic [7:0] OP_DEC  = 8'h01;
  localparam logic [7:0] OP_INC  = 8'h02;
  localparam logic [7:0] OP_NOT  = 8'h03;
  localparam logic [7:0] OP_SETC = 8'h04;
  localparam logic [7:0] OP_CLRC = 8'h05;
  localparam logic [7:0] OP_SWAP = 8'h0A;

  localparam logic [4:0] OP_SETB_PFX = 5'b01100;
  localparam logic [4:0] OP_CLRB_PFX = 5'b01101;

  function automatic logic is_legal(input logic [7:0] op);
    logic ok;
    if (op[7]) begin
      ok = (op[6:1] >= 6'h04) && (op[6:1] <= 6'h0F);
    end else if ((op[7:3] == OP_SETB_PFX) || (op[7:3] == OP_CLRB_PFX)) begin
      ok = 1'b1;
    end else begin
      ok = (op >= OP_DEC) && (op <= OP_SWAP);
    end
    return ok;
  endfunction

  function automatic logic is_flag_only(input logic [7:0] op);
    return (op == OP_SETC) || (op == OP_CLRC);
  endfunction

  function automatic logic is_mul(input logic [7:0] op);
    return op[7] && ((op[6:1] == 6'h08) || (op[6:1] == 6'h09));
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x8 register file: async clear, rd/rs/debug combinational reads, primary plus optional second write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS = NREGS_C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rd_addr,
  input  logic [2:0] rs_addr,
  input  logic [2:0] dbg_addr,
  output logic [7:0] rd_data,
  output logic [7:0] rs_data,
  output logic [7:0] dbg_data,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic       we2,
  input  logic [2:0] waddr2,
  input  logic [7:0] wdata2
);

  logic [7:0] mem_r [NREGS];

  assign rd_data  = mem_r[rd_addr];
  assign rs_data  = mem_r[rs_addr];
  assign dbg_data = mem_r[dbg_addr];

  // Storage update: clear on reset, otherwise up to two writes per cycle to distinct entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (we) begin
        mem_r[waddr] <= wdata;
      end
      if (we2) begin
        mem_r[waddr2] <= wdata2;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer in front of the 8-bit ALU: operand fetch, one-cycle issue, result/flag writeback.
// Optional build macro ALU_SEQ_MULH_EN: MUL also writes the high product byte into rf[rd+1].
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr_op,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rs,
  input  logic [7:0] instr_imm,
  input  logic       dbg_we,
  input  logic [2:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic [7:0] dbg_rdata,
  output logic       alu_enable,
  output logic [7:0] alu_operation,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_cpu_carry,
  input  logic [7:0] alu_result_l,
  input  logic [7:0] alu_result_h,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic       wb_valid,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_s,
  output logic       ill_op
);

  state_t     state_r;
  logic       ready_r;
  logic       alu_enable_r;
  logic [7:0] alu_operation_r;
  logic [7:0] alu_op1_r;
  logic [7:0] alu_op2_r;
  logic [7:0] op_r;
  logic [2:0] rd_r;
  logic       wb_valid_r;
  logic [2:0] wb_rd_r;
  logic       flag_c_r;
  logic       flag_z_r;
  logic       flag_s_r;
  logic       ill_op_r;

  logic       accept_s;
  logic [7:0] rd_data_s;
  logic [7:0] rs_data_s;
  logic [7:0] op2_s;
  logic       we_s;
  logic [2:0] waddr_s;
  logic [7:0] wdata_s;
  logic       we2_s;
  logic [2:0] waddr2_s;
  logic [7:0] wdata2_s;

  assign accept_s = instr_valid && ready_r;

  alu_seq_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (instr_rd),
    .rs_addr  (instr_rs),
    .dbg_addr (dbg_addr),
    .rd_data  (rd_data_s),
    .rs_data  (rs_data_s),
    .dbg_data (dbg_rdata),
    .we       (we_s),
    .waddr    (waddr_s),
    .wdata    (wdata_s),
    .we2      (we2_s),
    .waddr2   (waddr2_s),
    .wdata2   (wdata2_s)
  );

  // Second operand: literal, register, or zero for single-operand ops
  always_comb begin
    op2_s = 8'h00;
    if (instr_op[7] && !instr_op[0]) begin
      op2_s = instr_imm;
    end else if (instr_op[7]) begin
      op2_s = rs_data_s;
    end else begin
      op2_s = 8'h00;
    end
  end

  // Register-file write steering: writeback owns the port in WB, the debug port only in an idle cycle without handshake
  always_comb begin
    we_s    = 1'b0;
    waddr_s = dbg_addr;
    wdata_s = dbg_wdata;
    if (state_r == WB) begin
      we_s    = !is_flag_only(op_r);
      waddr_s = rd_r;
      wdata_s = alu_result_l;
    end else begin
      we_s    = dbg_we && (state_r == IDLE) && !accept_s;
      waddr_s = dbg_addr;
      wdata_s = dbg_wdata;
    end
  end

  // High product byte writes the next register up (wrapping 7 -> 0)
  always_comb begin
    waddr2_s = rd_r + 3'd1;
    wdata2_s = alu_result_h;
`ifdef ALU_SEQ_MULH_EN
    if (state_r == WB) begin
      we2_s = is_mul(op_r);
    end else begin
      we2_s = 1'b0;
    end
`else
    we2_s = 1'b0;
`endif
  end

  // Sequencer FSM with all handshake/ALU/writeback outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      ready_r         <= 1'b1;
      alu_enable_r    <= 1'b0;
      alu_operation_r <= 8'h00;
      alu_op1_r       <= 8'h00;
      alu_op2_r       <= 8'h00;
      op_r            <= 8'h00;
      rd_r            <= 3'd0;
      wb_valid_r      <= 1'b0;
      wb_rd_r         <= 3'd0;
      flag_c_r        <= 1'b0;
      flag_z_r        <= 1'b0;
      flag_s_r        <= 1'b0;
      ill_op_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && is_legal(instr_op)) begin
            state_r         <= ISSUE;
            ready_r         <= 1'b0;
            alu_enable_r    <= 1'b1;
            alu_operation_r <= instr_op;
            alu_op1_r       <= rd_data_s;
            alu_op2_r       <= op2_s;
            op_r            <= instr_op;
            rd_r            <= instr_rd;
          end else if (accept_s) begin
            state_r  <= ILL;
            ready_r  <= 1'b0;
            ill_op_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          state_r         <= WB;
          alu_enable_r    <= 1'b0;
          alu_operation_r <= 8'h00;
          alu_op1_r       <= 8'h00;
          alu_op2_r       <= 8'h00;
          wb_valid_r      <= !is_flag_only(op_r);
          wb_rd_r         <= is_flag_only(op_r) ? 3'd0 : rd_r;
        end
        WB: begin
          state_r    <= IDLE;
          ready_r    <= 1'b1;
          wb_valid_r <= 1'b0;
          wb_rd_r    <= 3'd0;
          flag_c_r   <= alu_carry;
          flag_z_r   <= alu_zero;
          flag_s_r   <= alu_sign;
        end
        ILL: begin
          state_r  <= IDLE;
          ready_r  <= 1'b1;
          ill_op_r <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          ready_r      <= 1'b1;
          alu_enable_r <= 1'b0;
          wb_valid_r   <= 1'b0;
          ill_op_r     <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready   = ready_r;
  assign alu_enable    = alu_enable_r;
  assign alu_operation = alu_operation_r;
  assign alu_op1       = alu_op1_r;
  assign alu_op2       = alu_op2_r;
  assign alu_cpu_carry = flag_c_r;
  assign wb_valid      = wb_valid_r;
  assign wb_rd         = wb_rd_r;
  assign wb_data       = wb_valid_r ? alu_result_l : 8'h00;
  assign flag_c        = flag_c_r;
  assign flag_z        = flag_z_r;
  assign flag_s        = flag_s_r;
  assign ill_op        = ill_op_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered-ALU stand-in.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_rs;
  logic [7:0] instr_imm;
  logic       dbg_we;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic [7:0] dbg_rdata;
  logic       alu_enable;
  logic [7:0] alu_operation;
  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic       alu_cpu_carry;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_c;
  logic       flag_z;
  logic       flag_s;
  logic       ill_op;

  // ALU stand-in bus: {h[7:0], l[7:0], carry, zero, sign}
  logic [18:0] alu_bus = 19'd0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs      (instr_rs),
    .instr_imm     (instr_imm),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_rdata     (dbg_rdata),
    .alu_enable    (alu_enable),
    .alu_operation (alu_operation),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_cpu_carry (alu_cpu_carry),
    .alu_result_l  (alu_bus[10:3]),
    .alu_result_h  (alu_bus[18:11]),
    .alu_carry     (alu_bus[2]),
    .alu_zero      (alu_bus[1]),
    .alu_sign      (alu_bus[0]),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flag_c        (flag_c),
    .flag_z        (flag_z),
    .flag_s        (flag_s),
    .ill_op        (ill_op)
  );

  function automatic logic [18:0] alu_calc(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
    logic [15:0] p;
    logic [8:0]  s;
    case (op)
      8'h04: return {8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      8'h05: return {8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      8'h88, 8'h89: begin
        s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        return {8'h00, s[7:0], s[8], (s[7:0] == 8'h00), s[7]};
      end
      8'h90, 8'h91, 8'h92, 8'h93: begin
        p = a * b;
        return {p[15:8], p[7:0], 1'b0, (p[7:0] == 8'h00), p[7]};
      end
      default: return {8'h00, a, 1'b0, (a == 8'h00), a[7]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_enable) begin
      alu_bus <= alu_calc(alu_operation, alu_op1, alu_op2, alu_cpu_carry);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rf_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_load(input logic [2:0] addr, input logic [7:0] data);
    dbg_we    = 1'b1;
    dbg_addr  = addr;
    dbg_wdata = data;
    step();
    dbg_we    = 1'b0;
  endtask

  task automatic offer(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [7:0] imm);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_imm   = imm;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 8'h00; instr_rd = 3'd0; instr_rs = 3'd0;
    instr_imm = 8'h00; dbg_we = 1'b0; dbg_addr = 3'd3; dbg_wdata = 8'h00;
    #12;
    chk("rst_ready", {7'd0, instr_ready}, 8'h01);
    chk("rst_alu_en", {7'd0, alu_enable}, 8'h00);
    chk("rst_wb_valid", {7'd0, wb_valid}, 8'h00);
    chk("rst_flags", {5'd0, flag_c, flag_z, flag_s}, 8'h00);
    chk("rst_rf3", dbg_rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    dbg_load(3'd1, 8'h10);
    dbg_load(3'd4, 8'h10);
    dbg_load(3'd7, 8'h20);
    dbg_load(3'd2, 8'h10);
    dbg_load(3'd0, 8'h55);
    rf_chk("dbg_load_rf1", 3'd1, 8'h10);

    // ADD literal with a coincident debug write that must be dropped
    offer(8'h88, 3'd1, 3'd0, 8'h05);
    dbg_we = 1'b1; dbg_addr = 3'd3; dbg_wdata = 8'hAA;
    step();
    dbg_we = 1'b0; instr_valid = 1'b0;
    chk("add_issue_en", {7'd0, alu_enable}, 8'h01);
    chk("add_issue_opc", alu_operation, 8'h88);
    chk("add_issue_op1", alu_op1, 8'h10);
    chk("add_issue_op2", alu_op2, 8'h05);
    chk("add_issue_cin", {7'd0, alu_cpu_carry}, 8'h00);
    chk("add_issue_ready", {7'd0, instr_ready}, 8'h00);
    step();
    chk("add_wb_valid", {7'd0, wb_valid}, 8'h01);
    chk("add_wb_rd", {5'd0, wb_rd}, 8'h01);
    chk("add_wb_data", wb_data, 8'h15);
    chk("add_wb_en_low", {7'd0, alu_enable}, 8'h00);
    chk("add_wb_op1_zero", alu_op1, 8'h00);
    chk("add_wb_ready", {7'd0, instr_ready}, 8'h00);
    step();
    chk("add_done_ready", {7'd0, instr_ready}, 8'h01);
    chk("add_done_wbv", {7'd0, wb_valid}, 8'h00);
    chk("add_done_flags", {5'd0, flag_c, flag_z, flag_s}, 8'h00);
    rf_chk("add_rf1", 3'd1, 8'h15);
    rf_chk("dbg_drop_rf3", 3'd3, 8'h00);

    // SETC: flags only, no register write
    offer(8'h04, 3'd0, 3'd0, 8'h00);
    step();
    instr_valid = 1'b0;
    chk("setc_issue_opc", alu_operation, 8'h04);
    chk("setc_issue_op1", alu_op1, 8'h55);
    chk("setc_issue_op2", alu_op2, 8'h00);
    step();
    chk("setc_wb_valid", {7'd0, wb_valid}, 8'h00);
    step();
    chk("setc_flag_c", {7'd0, flag_c}, 8'h01);
    chk("setc_cpu_carry", {7'd0, alu_cpu_carry}, 8'h01);
    rf_chk("setc_rf0", 3'd0, 8'h55);

    // ADD with carry-in, then MUL offered back to back with valid held high
    offer(8'h88, 3'd4, 3'd0, 8'h05);
    step();
    offer(8'h93, 3'd7, 3'd2, 8'h00);
    chk("adc_issue_cin", {7'd0, alu_cpu_carry}, 8'h01);
    chk("adc_issue_opc", alu_operation, 8'h88);
    chk("adc_issue_op1", alu_op1, 8'h10);
    chk("adc_issue_op2", alu_op2, 8'h05);
    step();
    chk("adc_wb_data", wb_data, 8'h16);
    chk("adc_wb_rd", {5'd0, wb_rd}, 8'h04);
    chk("b2b_no_early_en1", {7'd0, alu_enable}, 8'h00);
    step();
    chk("b2b_no_early_en2", {7'd0, alu_enable}, 8'h00);
    chk("b2b_ready", {7'd0, instr_ready}, 8'h01);
    step();
    instr_valid = 1'b0;
    chk("mul_issue_en", {7'd0, alu_enable}, 8'h01);
    chk("mul_issue_opc", alu_operation, 8'h93);
    chk("mul_issue_op1", alu_op1, 8'h20);
    chk("mul_issue_op2", alu_op2, 8'h10);
    chk("mul_issue_cin", {7'd0, alu_cpu_carry}, 8'h00);
    rf_chk("adc_rf4", 3'd4, 8'h16);
    step();
    chk("mul_wb_valid", {7'd0, wb_valid}, 8'h01);
    chk("mul_wb_rd", {5'd0, wb_rd}, 8'h07);
    chk("mul_wb_data", wb_data, 8'h00);
    step();
    rf_chk("mul_rf7", 3'd7, 8'h00);
`ifdef ALU_SEQ_MULH_EN
    rf_chk("mul_rf0_high", 3'd0, 8'h02);
`else
    rf_chk("mul_rf0_kept", 3'd0, 8'h55);
`endif
    chk("mul_flags", {5'd0, flag_c, flag_z, flag_s}, 8'h02);

    // Illegal opcodes: ill_op pulse, no ALU activity, no state change
    offer(8'h80, 3'd4, 3'd0, 8'h00);
    step();
    instr_valid = 1'b0;
    chk("ill80_pulse", {7'd0, ill_op}, 8'h01);
    chk("ill80_no_en", {7'd0, alu_enable}, 8'h00);
    chk("ill80_ready_low", {7'd0, instr_ready}, 8'h00);
    step();
    chk("ill80_pulse_end", {7'd0, ill_op}, 8'h00);
    chk("ill80_ready", {7'd0, instr_ready}, 8'h01);
    chk("ill80_no_en2", {7'd0, alu_enable}, 8'h00);
    chk("ill80_no_wb", {7'd0, wb_valid}, 8'h00);
    chk("ill80_flags", {5'd0, flag_c, flag_z, flag_s}, 8'h02);
    rf_chk("ill80_rf4", 3'd4, 8'h16);
    offer(8'h0B, 3'd1, 3'd0, 8'h00);
    step();
    instr_valid = 1'b0;
    chk("ill0b_pulse", {7'd0, ill_op}, 8'h01);
    step();
    offer(8'h6F, 3'd3, 3'd0, 8'h00);
    step();
    instr_valid = 1'b0;
    chk("clrb_legal_en", {7'd0, alu_enable}, 8'h01);
    chk("clrb_no_ill", {7'd0, ill_op}, 8'h00);
    step();
    step();

    // Reset during ISSUE abandons the instruction
    offer(8'h88, 3'd4, 3'd0, 8'h01);
    step();
    instr_valid = 1'b0;
    chk("rstmid_issue_en", {7'd0, alu_enable}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_en_drop", {7'd0, alu_enable}, 8'h00);
    chk("rstmid_ready", {7'd0, instr_ready}, 8'h01);
    rf_chk("rstmid_rf4", 3'd4, 8'h00);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rstmid_no_wb1", {7'd0, wb_valid}, 8'h00);
    step();
    chk("rstmid_no_wb2", {7'd0, wb_valid}, 8'h00);
    chk("rstmid_ready_after", {7'd0, instr_ready}, 8'h01);
    chk("rstmid_flags", {5'd0, flag_c, flag_z, flag_s}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
